// File: rtl/ecc_status_collector.sv
// Registered stage behind the SECDED decoder: one-deep output register plus
// saturating error counters, a first-error log and a health/interrupt FSM.

package ecc_status_collector_pkg;

  // Smallest m with 2**m >= m + k + 1.
  function automatic int calculate_m(input int k);
    int m;
    m = 0;
    for (int i = 1; i < 31; i++) begin
      if (m == 0 && (1 << i) >= i + k + 1) begin
        m = i;
      end
    end
    return m;
  endfunction

endpackage

module ecc_status_collector
  import ecc_status_collector_pkg::*;
#(
  parameter int K      = 8,
  parameter int M      = calculate_m(K),
  parameter int CNT_W  = 16,
  parameter int THRESH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [K-1:0]     q_i,
  input  logic [M-1:0]     syndrome_i,
  input  logic             sb_err_i,
  input  logic             db_err_i,
  input  logic             sb_fix_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [K-1:0]     out_data_o,
  output logic             out_uncorr_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic             log_valid_o,
  output logic [M-1:0]     log_syn_o,
  output logic [CNT_W-1:0] log_idx_o,
  output logic             log_db_o,
  output logic [1:0]       health_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);

  typedef enum logic [1:0] {
    HEALTH_OK       = 2'd0,
    HEALTH_DEGRADED = 2'd1,
    HEALTH_FAILED   = 2'd2
  } health_e;

  typedef enum logic {
    LOG_EMPTY    = 1'b0,
    LOG_CAPTURED = 1'b1
  } log_e;

  logic             out_valid_q, out_valid_d;
  logic [K-1:0]     out_data_q, out_data_d;
  logic             out_uncorr_q, out_uncorr_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  log_e             log_state_q, log_state_d;
  logic [M-1:0]     log_syn_q, log_syn_d;
  logic [CNT_W-1:0] log_idx_q, log_idx_d;
  logic             log_db_q, log_db_d;
  health_e          health_q, health_d;
  logic             irq_q, irq_d;

  logic             accept;
  logic             sb_event;
  logic             db_event;

  // Values after an optional clear; the accepted word's event is applied on top.
  logic [CNT_W-1:0] sb_base, db_base, word_base;
  log_e             log_base;
  health_e          health_base;

  // sb_fix_i only says whether the decoder repaired the bit; it does not alter counting.
  logic unused_sb_fix;
  assign unused_sb_fix = sb_fix_i;

  assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign db_event   = accept && db_err_i;
  assign sb_event   = accept && sb_err_i && !db_err_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_uncorr_d = out_uncorr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = q_i;
      out_uncorr_d = db_err_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    sb_base     = clr_i ? '0 : sb_cnt_q;
    db_base     = clr_i ? '0 : db_cnt_q;
    word_base   = clr_i ? '0 : word_cnt_q;
    log_base    = clr_i ? LOG_EMPTY : log_state_q;
    health_base = clr_i ? HEALTH_OK : health_q;

    sb_cnt_d    = sb_base;
    db_cnt_d    = db_base;
    word_cnt_d  = word_base;
    log_state_d = log_base;
    log_syn_d   = clr_i ? '0 : log_syn_q;
    log_idx_d   = clr_i ? '0 : log_idx_q;
    log_db_d    = clr_i ? 1'b0 : log_db_q;
    health_d    = health_base;

    if (sb_event && sb_base != CNT_MAX) begin
      sb_cnt_d = sb_base + 1'b1;
    end
    if (db_event && db_base != CNT_MAX) begin
      db_cnt_d = db_base + 1'b1;
    end
    if (accept) begin
      word_cnt_d = word_base + 1'b1;
    end

    if (log_base == LOG_EMPTY && (sb_event || db_event)) begin
      log_state_d = LOG_CAPTURED;
      log_syn_d   = syndrome_i;
      log_idx_d   = word_base;
      log_db_d    = db_err_i;
    end

    // A saturated counter never equals THRESH-1, so DEGRADED is not re-entered.
    case (health_base)
      HEALTH_OK: begin
        if (db_event) begin
          health_d = HEALTH_FAILED;
        end else if (sb_event && sb_base == THRESH_M1) begin
          health_d = HEALTH_DEGRADED;
        end
      end
      HEALTH_DEGRADED: begin
        if (db_event) begin
          health_d = HEALTH_FAILED;
        end
      end
      default: health_d = health_base;
    endcase

    // Starting from the post-clear state, any change can only be an upgrade.
    irq_d = (health_d != health_base);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_uncorr_q <= 1'b0;
      sb_cnt_q     <= '0;
      db_cnt_q     <= '0;
      word_cnt_q   <= '0;
      log_state_q  <= LOG_EMPTY;
      log_syn_q    <= '0;
      log_idx_q    <= '0;
      log_db_q     <= 1'b0;
      health_q     <= HEALTH_OK;
      irq_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_uncorr_q <= out_uncorr_d;
      sb_cnt_q     <= sb_cnt_d;
      db_cnt_q     <= db_cnt_d;
      word_cnt_q   <= word_cnt_d;
      log_state_q  <= log_state_d;
      log_syn_q    <= log_syn_d;
      log_idx_q    <= log_idx_d;
      log_db_q     <= log_db_d;
      health_q     <= health_d;
      irq_q        <= irq_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_uncorr_o = out_uncorr_q;
  assign sb_cnt_o     = sb_cnt_q;
  assign db_cnt_o     = db_cnt_q;
  assign word_cnt_o   = word_cnt_q;
  assign log_valid_o  = (log_state_q == LOG_CAPTURED);
  assign log_syn_o    = log_syn_q;
  assign log_idx_o    = log_idx_q;
  assign log_db_o     = log_db_q;
  assign health_o     = health_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_ecc_status_collector.sv
// Self-checking bench for ecc_status_collector: directed table, corner sequences
// and randomized traffic against a behavioural model.

module tb_ecc_status_collector;

  localparam int K      = 8;
  localparam int M      = 4;
  localparam int CNT_W  = 16;
  localparam int THRESH = 8;
  localparam int MAXC   = 65535;

  logic             clk;
  logic             rst, in_valid, sb_err, db_err, sb_fix, out_ready, clr;
  logic [K-1:0]     q;
  logic [M-1:0]     syn;
  logic             in_ready, out_valid, out_uncorr, log_valid, log_db, irq;
  logic [K-1:0]     out_data;
  logic [CNT_W-1:0] sb_cnt, db_cnt, word_cnt, log_idx;
  logic [M-1:0]     log_syn;
  logic [1:0]       health;

  // Second instance with THRESH=1, shares all inputs.
  logic             unused_rdy1, unused_ov1, unused_unc1, unused_lv1, unused_ldb1;
  logic [K-1:0]     unused_data1;
  logic [CNT_W-1:0] unused_sb1, unused_db1, unused_wc1, unused_idx1;
  logic [M-1:0]     unused_syn1;
  logic [1:0]       health1;
  logic             irq1;

  ecc_status_collector #(.K(K), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .q_i(q), .syndrome_i(syn), .sb_err_i(sb_err), .db_err_i(db_err), .sb_fix_i(sb_fix),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_uncorr_o(out_uncorr), .clr_i(clr), .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt),
    .word_cnt_o(word_cnt), .log_valid_o(log_valid), .log_syn_o(log_syn),
    .log_idx_o(log_idx), .log_db_o(log_db), .health_o(health), .irq_o(irq)
  );

  ecc_status_collector #(.K(K), .CNT_W(CNT_W), .THRESH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(unused_rdy1),
    .q_i(q), .syndrome_i(syn), .sb_err_i(sb_err), .db_err_i(db_err), .sb_fix_i(sb_fix),
    .out_valid_o(unused_ov1), .out_ready_i(out_ready), .out_data_o(unused_data1),
    .out_uncorr_o(unused_unc1), .clr_i(clr), .sb_cnt_o(unused_sb1), .db_cnt_o(unused_db1),
    .word_cnt_o(unused_wc1), .log_valid_o(unused_lv1), .log_syn_o(unused_syn1),
    .log_idx_o(unused_idx1), .log_db_o(unused_ldb1), .health_o(health1), .irq_o(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit verbose = 1'b1;

  // Behavioural model state
  int m_ov, m_data, m_unc, m_sb, m_db, m_word, m_logv, m_syn, m_idx, m_ldb, m_health, m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_data = 0; m_unc = 0; m_sb = 0; m_db = 0; m_word = 0;
    m_logv = 0; m_syn = 0; m_idx = 0; m_ldb = 0; m_health = 0; m_irq = 0;
  endtask

  // One clock: drive inputs, check ready before the edge, update model, check all outputs.
  task automatic step(input bit v, input logic [7:0] qd, input logic [3:0] sd,
                      input bit sb, input bit db, input bit ordy, input bit cl, input bit r);
    bit acc, ready;
    int h_before;
    in_valid = v; q = qd; syn = sd; sb_err = sb; db_err = db; sb_fix = sb & ~db;
    out_ready = ordy; clr = cl; rst = r;
    #2;
    ready = !r && (m_ov == 0 || ordy);
    chk("in_ready", 32'(in_ready), 32'(ready));
    @(posedge clk);
    #1;
    acc = v && ready;
    if (r) begin
      model_reset();
    end else begin
      if (cl) begin
        m_sb = 0; m_db = 0; m_word = 0; m_logv = 0; m_syn = 0; m_idx = 0; m_ldb = 0; m_health = 0;
      end
      h_before = m_health;
      if (acc) begin
        m_ov = 1; m_data = qd; m_unc = db;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (acc && (sb || db) && m_logv == 0) begin
        m_logv = 1; m_syn = sd; m_idx = m_word; m_ldb = db;
      end
      if (acc && db) begin
        if (m_db < MAXC) m_db++;
        m_health = 2;
      end else if (acc && sb) begin
        if (m_sb < MAXC) begin
          m_sb++;
          if (m_sb == THRESH && m_health == 0) m_health = 1;
        end
      end
      if (acc) m_word = (m_word + 1) % (MAXC + 1);
      m_irq = (m_health > h_before) ? 1 : 0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_uncorr", 32'(out_uncorr), 32'(m_unc));
    chk("sb_cnt", 32'(sb_cnt), 32'(m_sb));
    chk("db_cnt", 32'(db_cnt), 32'(m_db));
    chk("word_cnt", 32'(word_cnt), 32'(m_word));
    chk("log_valid", 32'(log_valid), 32'(m_logv));
    chk("log_syn", 32'(log_syn), 32'(m_syn));
    chk("log_idx", 32'(log_idx), 32'(m_idx));
    chk("log_db", 32'(log_db), 32'(m_ldb));
    chk("health", 32'(health), 32'(m_health));
    chk("irq", 32'(irq), 32'(m_irq));
    if (verbose)
      $display("t=%0t rst=%0b clr=%0b v=%0b q=%02h syn=%0h sb=%0b db=%0b ordy=%0b | ov=%0b data=%02h word=%0d sb=%0d db=%0d log=%0b/%0h/%0d h=%0d irq=%0b",
               $time, r, cl, v, qd, sd, sb, db, ordy, out_valid, out_data, word_cnt,
               sb_cnt, db_cnt, log_valid, log_syn, log_idx, health, irq);
  endtask

  typedef struct {
    bit v; logic [7:0] q; logic [3:0] syn; bit sb; bit db; bit ordy; bit clr;
    bit e_ov; logic [7:0] e_data; int e_word; int e_sb; bit e_logv; logic [3:0] e_syn;
    int e_idx; int e_health; int e_h1; bit e_irq1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 8'hAF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAF, 1, 0, 1'b0, 4'h0, 0, 0, 0, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2, 0, 1'b0, 4'h0, 0, 0, 0, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 3, 0, 1'b0, 4'h0, 0, 0, 0, 1'b0};
    vecs[3] = '{1'b1, 8'h33, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 4, 1, 1'b1, 4'h5, 3, 0, 1, 1'b1};
    vecs[4] = '{1'b1, 8'h44, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 5, 2, 1'b1, 4'h5, 3, 0, 1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 5, 2, 1'b1, 4'h5, 3, 0, 1, 1'b0};

    model_reset();
    step(1, 8'h5A, 4'h0, 1, 1, 1, 0, 1);
    step(1, 8'h5A, 4'h0, 1, 1, 1, 0, 1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_health", 32'(health), 32'd0);
    chk("reset_log_valid", 32'(log_valid), 32'd0);

    // Test plan 1-2 plus THRESH=1 instance
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].v, vecs[i].q, vecs[i].syn, vecs[i].sb, vecs[i].db, vecs[i].ordy, vecs[i].clr, 0);
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_word", i), 32'(word_cnt), 32'(vecs[i].e_word));
      chk($sformatf("vec%0d_sb", i), 32'(sb_cnt), 32'(vecs[i].e_sb));
      chk($sformatf("vec%0d_logv", i), 32'(log_valid), 32'(vecs[i].e_logv));
      chk($sformatf("vec%0d_syn", i), 32'(log_syn), 32'(vecs[i].e_syn));
      chk($sformatf("vec%0d_idx", i), 32'(log_idx), 32'(vecs[i].e_idx));
      chk($sformatf("vec%0d_health", i), 32'(health), 32'(vecs[i].e_health));
      chk($sformatf("vec%0d_health_t1", i), 32'(health1), 32'(vecs[i].e_h1));
      chk($sformatf("vec%0d_irq_t1", i), 32'(irq1), 32'(vecs[i].e_irq1));
    end

    // Test plan 3: eight sb words after a clear
    step(0, 8'h00, 4'h0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h80 + i), 4'h6, 1, 0, 1, 0, 0);
      chk("t3_health", 32'(health), (i == 7) ? 32'd1 : 32'd0);
      chk("t3_irq", 32'(irq), (i == 7) ? 32'd1 : 32'd0);
    end
    step(0, 8'h00, 4'h0, 0, 0, 1, 0, 0);
    chk("t3_irq_drop", 32'(irq), 32'd0);

    // Test plan 4: db word then sb word
    step(1, 8'hD0, 4'hC, 0, 1, 1, 0, 0);
    chk("t4_db_cnt", 32'(db_cnt), 32'd1);
    chk("t4_uncorr", 32'(out_uncorr), 32'd1);
    chk("t4_health", 32'(health), 32'd2);
    chk("t4_irq", 32'(irq), 32'd1);
    step(1, 8'hD1, 4'h7, 1, 0, 1, 0, 0);
    chk("t4_health_sticky", 32'(health), 32'd2);
    chk("t4_no_irq", 32'(irq), 32'd0);

    // Test plan 5: backpressure
    step(1, 8'h55, 4'h0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h66, 4'h9, 1, 0, 0, 0, 0);
      chk("t5_hold_data", 32'(out_data), 32'h55);
      chk("t5_hold_word", 32'(word_cnt), 32'd11);
      chk("t5_ready_low", 32'(in_ready), 32'd0);
      chk("t5_hold_sb", 32'(sb_cnt), 32'd9);
    end
    step(1, 8'h66, 4'h9, 0, 0, 1, 0, 0);
    chk("t5_release_data", 32'(out_data), 32'h66);
    chk("t5_release_word", 32'(word_cnt), 32'd12);
    step(0, 8'h00, 4'h0, 0, 0, 1, 0, 0);
    chk("t5_drain", 32'(out_valid), 32'd0);

    // Test plan 6: clear with same-cycle db accept
    step(1, 8'h77, 4'hA, 0, 1, 1, 1, 0);
    chk("t6_sb", 32'(sb_cnt), 32'd0);
    chk("t6_db", 32'(db_cnt), 32'd1);
    chk("t6_word", 32'(word_cnt), 32'd1);
    chk("t6_idx", 32'(log_idx), 32'd0);
    chk("t6_logdb", 32'(log_db), 32'd1);
    chk("t6_health", 32'(health), 32'd2);
    chk("t6_irq", 32'(irq), 32'd1);

    // Word counter wrap and sb saturation
    verbose = 1'b0;
    step(1, 8'h01, 4'h1, 1, 0, 1, 1, 0);
    for (int i = 0; i < MAXC; i++) begin
      step(1, 8'($urandom), 4'($urandom_range(1, 15)), 1, 0, 1, 0, 0);
    end
    chk("wrap_word", 32'(word_cnt), 32'd0);
    chk("sat_sb", 32'(sb_cnt), 32'hFFFF);
    step(1, 8'h02, 4'h2, 1, 0, 1, 0, 0);
    chk("sat_sb_hold", 32'(sb_cnt), 32'hFFFF);
    chk("sat_word_next", 32'(word_cnt), 32'd1);
    chk("sat_no_irq", 32'(irq), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int e;
      e = int'($urandom_range(0, 7));
      step(bit'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
           bit'(e < 2), bit'(e == 7), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_status_collector.md
# ecc_status_collector

Sequential stage directly downstream of the combinational Hamming SECDED decoder (`top`, K=8). It accepts one decoded word per valid/ready handshake and registers the corrected data for the consumer with one cycle of latency. Alongside the data path it keeps saturating single-bit and double-bit error counters, captures the first error event, and runs a three-state health FSM that raises an interrupt pulse.

## Interface
- K, 8, information bits per word.
- M, calculate_m(K) (=4 for K=8), syndrome width; smallest m with 2**m >= m+K+1.
- CNT_W, 16, width of all counters.
- THRESH, 8, single-bit error count that moves health to DEGRADED; legal range 1..2**CNT_W-1.

Ports:
- clk_i  in  1  single clock; all flops on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  decoder word present.
- in_ready_o  out  1  stage can accept.
- q_i  in  K  corrected data from the decoder (q_o).
- syndrome_i  in  M  decoder syndrome.
- sb_err_i / db_err_i / sb_fix_i  in  1 each  decoder status flags.
- out_valid_o  out  1  registered word valid.
- out_ready_i  in  1  consumer accepts.
- out_data_o  out  K  registered q_i.
- out_uncorr_o  out  1  registered db_err_i; data is not trustworthy.
- clr_i  in  1  clears counters, the log, and health.
- sb_cnt_o / db_cnt_o  out  CNT_W each  error counters.
- word_cnt_o  out  CNT_W  index of the next accepted word.
- log_valid_o  out  1  first-error log holds an entry.
- log_syn_o  out  M  captured syndrome.
- log_idx_o  out  CNT_W  captured word index.
- log_db_o  out  1  the captured event was a double-bit error.
- health_o  out  2  0=OK, 1=DEGRADED, 2=FAILED.
- irq_o  out  1  one-cycle pulse on a health upgrade.

## Operation
**Handshake and data path**
- in_ready_o = !rst_i && (!out_valid_o || out_ready_i).
- accept = in_valid_i && in_ready_o.
- On accept, out_data_o and out_uncorr_o load the inputs and out_valid_o is set.
- Otherwise out_valid_o clears when out_ready_i is high; the output register holds while out_valid_o && !out_ready_i.

**Event classification (accepted words only)**
- db event = db_err_i.
- sb event = sb_err_i && !db_err_i.
- sb_fix_i is informational. An sb event with sb_fix_i=0 is still counted as sb.

**Counters**
- sb_cnt_o and db_cnt_o increment by 1 per event and saturate at 2**CNT_W-1.
- word_cnt_o increments on every accept and wraps 2**CNT_W-1 -> 0.

**First-error log**
- Two states: EMPTY and CAPTURED.
- EMPTY -> CAPTURED on the first accepted sb or db event. The log latches the syndrome, the current word_cnt_o (before increment) and log_db_o.
- In CAPTURED, all later events are ignored by the log.
- CAPTURED -> EMPTY only on clr_i.

**Health FSM**
- OK -> DEGRADED when an sb event takes sb_cnt from THRESH-1 to THRESH.
- OK or DEGRADED -> FAILED on any db event. A db event wins if it occurs in the same cycle as the DEGRADED condition.
- FAILED is sticky.
- clr_i returns any state to OK.
- irq_o pulses for exactly 1 cycle on each upgrade (OK->DEGRADED, OK->FAILED, DEGRADED->FAILED), never on a downgrade.

**clr_i with a same-cycle accept**
- Counters, log and health first clear, then the accepted word's event is applied.
- Example: a db accept during clr_i gives db_cnt=1, log CAPTURED with idx=0, health FAILED and an irq pulse.
- clr_i does not touch the data path.

## Timing
- Latency: a word accepted at edge N appears on out_data_o after edge N. Counters, log, health and irq all update at the same edge.
- Throughput: 1 word/cycle while out_ready_i is held high.

**Reset**
- Values after the reset edge: out_valid_o=0, out_data_o=0, out_uncorr_o=0.
- All counters 0, log EMPTY (log_syn_o=0, log_idx_o=0, log_db_o=0), health_o=0, irq_o=0.
- in_ready_o=0 while rst_i is high. Inputs are ignored during reset.
- Reset mid-transfer discards the held output word.

**Boundary cases**
- Backpressure: with out_valid_o=1 and out_ready_i=0, in_ready_o=0. No counts change.
- Saturated sb_cnt: no further increment, no repeated DEGRADED transition.
- THRESH=1: the first sb event goes OK -> DEGRADED.

## Test plan
1. Reset, then accept q_i=8'hAF clean with out_ready_i=1 -> next cycle out_data_o=8'hAF, out_valid_o=1, word_cnt_o=1, all error outputs 0, health_o=0.
2. Accept three clean words, then an sb word with syndrome_i=4'b0101 -> sb_cnt_o=1, log_valid_o=1, log_syn_o=4'b0101, log_idx_o=3, log_db_o=0. A later sb with syndrome 4'b0011 leaves the log unchanged.
3. Eight sb words back-to-back (THRESH=8) -> health_o goes 0->1 on the 8th. irq_o is high for exactly that one cycle.
4. Then one db word -> db_cnt_o=1, out_uncorr_o=1, health_o=2, one irq pulse. A further sb keeps health_o=2 with no irq.
5. Hold out_ready_i=0 for 5 cycles with in_valid_i=1 -> in_ready_o=0, out_data_o stable, no counter change. Release -> the held word drains, then the pending word is accepted.
6. Assert clr_i with a same-cycle db accept -> sb_cnt_o=0, db_cnt_o=1, word_cnt_o=1, log_idx_o=0, log_db_o=1, health_o=2, one irq pulse. Also check the wrap: force 65536 accepts -> word_cnt_o wraps to 0, and sb_cnt_o holds at 16'hFFFF when saturated.
